// File: rtl/if_pc_stage_if.sv
// Bundle of the fetch stage's datapath and control signals. The optional
// misalign_err line exists only when PC_ALIGN_CHECK_EN is defined.
interface if_pc_stage_if;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] instr;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        jump;
    logic [31:0] jump_target;
    logic [31:0] ifid_instr;
    logic [31:0] ifid_pc_plus4;
    logic        ifid_valid;
`ifdef PC_ALIGN_CHECK_EN
    logic        misalign_err;
`endif

    // master: the fetch stage itself; slave: incrementer, imem and decode side
    modport master (
        output pc, ifid_instr, ifid_pc_plus4, ifid_valid,
`ifdef PC_ALIGN_CHECK_EN
        output misalign_err,
`endif
        input  pc_plus4, instr, stall, branch_taken, branch_target, jump, jump_target
    );

    modport slave (
        input  pc, ifid_instr, ifid_pc_plus4, ifid_valid,
`ifdef PC_ALIGN_CHECK_EN
        input  misalign_err,
`endif
        output pc_plus4, instr, stall, branch_taken, branch_target, jump, jump_target
    );
endinterface

// File: rtl/if_pc_stage.sv
// Instruction-fetch stage: PC register, next-PC select and IF/ID register.
// Define PC_ALIGN_CHECK_EN to force redirect targets word-aligned and flag misalignment.
module if_pc_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic          clk,
    input  logic          rst,
    if_pc_stage_if.master bus
);
    logic [31:0] pc_reg, pc_next;
    logic [31:0] ifid_instr_reg, ifid_instr_next;
    logic [31:0] ifid_pc_plus4_reg, ifid_pc_plus4_next;
    logic        ifid_valid_reg, ifid_valid_next;
    logic        redirect;
    logic [31:0] redirect_target;
    logic [31:0] target_loaded;

    // Jump outranks branch; stall masks both so decode can re-present them later.
    assign redirect        = bus.jump | bus.branch_taken;
    assign redirect_target = bus.jump ? bus.jump_target : bus.branch_target;

`ifdef PC_ALIGN_CHECK_EN
    logic misalign_err_reg, misalign_err_next;
    assign target_loaded = {redirect_target[31:2], 2'b00};

    always_comb begin
        misalign_err_next = misalign_err_reg;
        if (!bus.stall && redirect && (redirect_target[1:0] != 2'b00))
            misalign_err_next = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) misalign_err_reg <= 1'b0;
        else     misalign_err_reg <= misalign_err_next;
    end

    assign bus.misalign_err = misalign_err_reg;
`else
    assign target_loaded = redirect_target;
`endif

    always_comb begin
        pc_next            = pc_reg;
        ifid_instr_next    = ifid_instr_reg;
        ifid_pc_plus4_next = ifid_pc_plus4_reg;
        ifid_valid_next    = ifid_valid_reg;
        if (bus.stall) begin
            pc_next = pc_reg;
        end else if (redirect) begin
            // Squash the wrong-path fetch sitting on instr this cycle.
            pc_next            = target_loaded;
            ifid_instr_next    = NOP_INSTR;
            ifid_pc_plus4_next = 32'h0;
            ifid_valid_next    = 1'b0;
        end else begin
            pc_next            = bus.pc_plus4;
            ifid_instr_next    = bus.instr;
            ifid_pc_plus4_next = bus.pc_plus4;
            ifid_valid_next    = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_reg            <= RESET_PC;
            ifid_instr_reg    <= NOP_INSTR;
            ifid_pc_plus4_reg <= 32'h0;
            ifid_valid_reg    <= 1'b0;
        end else begin
            pc_reg            <= pc_next;
            ifid_instr_reg    <= ifid_instr_next;
            ifid_pc_plus4_reg <= ifid_pc_plus4_next;
            ifid_valid_reg    <= ifid_valid_next;
        end
    end

    assign bus.pc            = pc_reg;
    assign bus.ifid_instr    = ifid_instr_reg;
    assign bus.ifid_pc_plus4 = ifid_pc_plus4_reg;
    assign bus.ifid_valid    = ifid_valid_reg;
endmodule
